// File: rtl/pool_act_engine.sv
// pool_act_engine: per-lane windowed max/average/bypass reduction with optional ReLU
// over a valid/ready stream, one registered D-lane result per window.
module pool_act_engine #(
  parameter int depth = 3,
  parameter int W = 16,
  parameter int MAXWL = 3,
  parameter int CW = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [1:0]                cfgMode,
  input  logic [CW-1:0]             cfgWinLog,
  input  logic                      cfgRelu,
  input  logic                      inValid,
  output logic                      inReady,
  input  logic [W*(1<<depth)-1:0]   inData,
  input  logic                      inLast,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [W*(1<<depth)-1:0]   outData,
  output logic                      outPartial,
  output logic                      busy
);
  localparam int D = 1 << depth;
  localparam int AW = W + MAXWL;
  localparam logic signed [AW-1:0] HI = AW'((1 << (W - 1)) - 1);
  localparam logic signed [AW-1:0] LO = ~HI;
  logic [MAXWL-1:0] cnt, nm1;
  logic [1:0] sh_mode, mode;
  logic [CW-1:0] sh_wl, wl, wl_in;
  logic sh_relu, relu, first, take, close, partial, avg;
  logic [W*D-1:0] res;
  assign inReady = !outValid || outReady;
  assign take = inValid && inReady;
  assign first = cnt == '0;
  assign busy = !first;
  assign wl_in = cfgWinLog > CW'(MAXWL) ? CW'(MAXWL) : cfgWinLog;
  // the first beat of a window sees the live config, later beats the shadow
  assign mode = first ? cfgMode : sh_mode;
  assign wl = first ? wl_in : sh_wl;
  assign relu = first ? cfgRelu : sh_relu;
  assign avg = mode == 2'b10;
  assign nm1 = mode == 2'b00 ? '0 : MAXWL'((1 << wl) - 1);
  assign close = cnt == nm1 || inLast;
  assign partial = inLast && cnt != nm1;
  for (genvar i = 0; i < D; i++) begin : g_lane
    logic signed [AW-1:0] acc, x, nxt, rnd, r;
    logic [W-1:0] q;
    assign x = {{MAXWL{inData[W*i+W-1]}}, inData[W*i +: W]};
    always_comb begin
      nxt = (first || mode == 2'b00) ? x : avg ? acc + x : (x > acc ? x : acc);
      rnd = wl == '0 ? '0 : AW'(1) << (wl - 1'b1);
      r = avg ? (nxt + rnd) >>> wl : nxt;
      q = r > HI ? HI[W-1:0] : r < LO ? LO[W-1:0] : r[W-1:0];
    end
    assign res[W*i +: W] = (relu && q[W-1]) ? '0 : q;
    always_ff @(posedge CLK or posedge RST)
      if (RST) acc <= '0;
      else if (take) acc <= nxt;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cnt <= '0;
      sh_mode <= '0;
      sh_wl <= '0;
      sh_relu <= 1'b0;
      outValid <= 1'b0;
      outData <= '0;
      outPartial <= 1'b0;
    end else begin
      if (take && first) begin
        sh_mode <= cfgMode;
        sh_wl <= wl_in;
        sh_relu <= cfgRelu;
      end
      if (take) cnt <= close ? '0 : cnt + 1'b1;
      if (take && close) begin
        outValid <= 1'b1;
        outData <= res;
        outPartial <= partial;
      end else if (outReady) outValid <= 1'b0;
    end
endmodule

// File: tb/tb_pool_act_engine.sv
// tb_pool_act_engine: directed stimulus with a window-level reference model
// checked against the DUT every cycle, plus literal expectations per scenario.
module tb_pool_act_engine;
  localparam int W = 16, D = 8, DW = W * D, MAXWL = 3;
  logic CLK = 1'b0, RST = 1'b1;
  logic [1:0] cfgMode = 2'b00, cfgWinLog = 2'b00;
  logic cfgRelu = 1'b0, inValid = 1'b0, inLast = 1'b0, outReady = 1'b1;
  logic [DW-1:0] inData = '0;
  logic inReady, outValid, outPartial, busy;
  logic [DW-1:0] outData;
  int total = 0, bad = 0;
  typedef struct { logic [DW-1:0] d; logic p; } res_t;
  res_t eq[$];
  logic [DW-1:0] win[$], got[$];
  logic gotp[$];
  int m_mode, m_wl, m_relu, m_n, m_v, m_acc;
  logic [DW-1:0] m_rd;
  bit m_take;

  pool_act_engine dut (
    .CLK(CLK), .RST(RST), .cfgMode(cfgMode), .cfgWinLog(cfgWinLog), .cfgRelu(cfgRelu),
    .inValid(inValid), .inReady(inReady), .inData(inData), .inLast(inLast),
    .outValid(outValid), .outReady(outReady), .outData(outData),
    .outPartial(outPartial), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  function automatic int lane(input logic [DW-1:0] d, input int i);
    return int'($signed(d[W*i +: W]));
  endfunction

  function automatic logic [DW-1:0] pk(input int a0, input int a1, input int a2);
    logic [DW-1:0] d;
    d = '0;
    d[0 +: W] = W'(a0);
    d[W +: W] = W'(a1);
    d[2*W +: W] = W'(a2);
    for (int i = 3; i < D; i++) d[W*i +: W] = W'(20 * i - 90 + a0);
    return d;
  endfunction

  function automatic logic [DW-1:0] ramp(input int off);
    logic [DW-1:0] d;
    for (int i = 0; i < D; i++) d[W*i +: W] = W'(100 * i - 300 + off);
    return d;
  endfunction

  // Reference: collect a window's beats, reduce them when it closes.
  always @(negedge CLK) begin
    if (RST) begin
      chk("rst_valid", outValid, 0);
      chk("rst_busy", busy, 0);
      eq.delete();
      win.delete();
    end else begin
      chk("out_valid", outValid, eq.size() != 0);
      if (eq.size() != 0) begin
        chk("out_data", outData, eq[0].d);
        chk("out_partial", outPartial, eq[0].p);
      end
      chk("busy", busy, win.size() != 0);
      chk("in_ready", inReady, eq.size() == 0 || outReady);
      m_take = inValid && (eq.size() == 0 || outReady);
      if (outValid && outReady) begin
        got.push_back(outData);
        gotp.push_back(outPartial);
      end
      if (eq.size() != 0 && outReady) void'(eq.pop_front());
      if (m_take) begin
        if (win.size() == 0) begin
          m_mode = int'(cfgMode);
          m_wl = cfgWinLog > MAXWL ? MAXWL : int'(cfgWinLog);
          m_relu = int'(cfgRelu);
        end
        win.push_back(inData);
        m_n = m_mode == 0 ? 1 : 1 << m_wl;
        if (win.size() == m_n || inLast) begin
          for (int i = 0; i < D; i++) begin
            m_acc = 0;
            for (int k = 0; k < win.size(); k++) begin
              m_v = lane(win[k], i);
              if (m_mode == 2) m_acc += m_v;
              else if (k == 0 || m_v > m_acc) m_acc = m_v;
            end
            if (m_mode == 2) m_acc = (m_acc + (m_wl > 0 ? 1 << (m_wl - 1) : 0)) >>> m_wl;
            if (m_acc > (1 << (W - 1)) - 1) m_acc = (1 << (W - 1)) - 1;
            if (m_acc < -(1 << (W - 1))) m_acc = -(1 << (W - 1));
            if (m_relu != 0 && m_acc < 0) m_acc = 0;
            m_rd[W*i +: W] = m_acc[W-1:0];
          end
          eq.push_back('{m_rd, inLast && win.size() < m_n});
          win.delete();
        end
      end
    end
  end

  task automatic beat(input logic [DW-1:0] d, input logic last);
    bit ok;
    ok = 0;
    inValid = 1'b1;
    inData = d;
    inLast = last;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge CLK);
      ok = inReady;
      @(posedge CLK);
      #1;
    end
    inValid = 1'b0;
    inLast = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: got no acceptance want acceptance within 50 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_lane(input string nm, input int idx, input int l, input int v);
    if (got.size() > idx) chk(nm, lane(got[idx], l), v);
    else chk({nm, "_missing"}, got.size(), idx + 1);
  endtask

  task automatic expect_part(input string nm, input int idx, input logic v);
    if (gotp.size() > idx) chk(nm, gotp[idx], v);
    else chk({nm, "_missing"}, gotp.size(), idx + 1);
  endtask

  initial begin
    int b;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out_valid", outValid, 0);
    chk("rst_out_data", outData, 0);
    chk("rst_out_partial", outPartial, 0);
    chk("rst_busy_lit", busy, 0);
    RST = 1'b0;
    idle(1);
    chk("ready_after_rst", inReady, 1);
    b = got.size();
    for (int k = 0; k < 4; k++) beat(ramp(k), 1'b0);
    idle(2);
    for (int k = 0; k < 4; k++) begin
      expect_lane("byp_l0", b + k, 0, -300 + k);
      expect_lane("byp_l7", b + k, 7, 400 + k);
      expect_part("byp_part", b + k, 1'b0);
    end
    cfgMode = 2'b01; cfgWinLog = 2'd2; cfgRelu = 1'b0;
    b = got.size();
    beat(pk(-5, 0, 0), 1'b0);
    cfgMode = 2'b10; cfgRelu = 1'b1;
    beat(pk(7, 0, 0), 1'b0);
    beat(pk(3, 0, 0), 1'b0);
    beat(pk(-9, 0, 0), 1'b0);
    cfgMode = 2'b11;
    beat(pk(-5, 1, 2), 1'b0);
    beat(pk(-2, 1, 2), 1'b0);
    beat(pk(-8, 1, 2), 1'b0);
    beat(pk(-1, 1, 2), 1'b0);
    idle(2);
    chk("max_count", got.size(), b + 2);
    expect_lane("max_l0", b, 0, 7);
    expect_lane("max_relu_l0", b + 1, 0, 0);
    expect_lane("max_relu_l1", b + 1, 1, 1);
    cfgMode = 2'b10; cfgRelu = 1'b0;
    b = got.size();
    beat(pk(1, 32767, -3), 1'b0);
    beat(pk(2, 32767, -3), 1'b0);
    beat(pk(2, 32767, -3), 1'b0);
    beat(pk(2, 32767, -2), 1'b0);
    idle(2);
    expect_lane("avg_l0", b, 0, 2);
    expect_lane("avg_l1", b, 1, 32767);
    expect_lane("avg_l2", b, 2, -3);
    cfgWinLog = 2'd3;
    b = got.size();
    beat(pk(8, 0, 0), 1'b0);
    beat(pk(8, 0, 0), 1'b0);
    beat(pk(8, 0, 0), 1'b1);
    cfgWinLog = 2'd1;
    beat(pk(4, -7, 0), 1'b0);
    beat(pk(6, -8, 0), 1'b1);
    idle(2);
    expect_lane("part_l0", b, 0, 3);
    expect_part("part_flag", b, 1'b1);
    expect_lane("clean_l0", b + 1, 0, 5);
    expect_lane("clean_l1", b + 1, 1, -7);
    expect_part("full_last_flag", b + 1, 1'b0);
    cfgMode = 2'b01; cfgWinLog = 2'd1;
    b = got.size();
    outReady = 1'b0;
    fork
      begin
        beat(pk(1, 0, 0), 1'b0);
        beat(pk(5, 0, 0), 1'b0);
        beat(pk(9, 0, 0), 1'b0);
        beat(pk(2, 0, 0), 1'b0);
        beat(pk(3, 0, 0), 1'b0);
        beat(pk(4, 0, 0), 1'b0);
      end
      begin
        idle(8);
        chk("bp_ready_low", inReady, 0);
        chk("bp_valid_held", outValid, 1);
        chk("bp_data_held", lane(outData, 0), 5);
        outReady = 1'b1;
      end
    join
    idle(2);
    chk("bp_count", got.size(), b + 3);
    expect_lane("bp_r0", b, 0, 5);
    expect_lane("bp_r1", b + 1, 0, 9);
    expect_lane("bp_r2", b + 2, 0, 4);
    cfgWinLog = 2'd2;
    b = got.size();
    beat(pk(100, 0, 0), 1'b0);
    beat(pk(200, 0, 0), 1'b0);
    RST = 1'b1;
    idle(1);
    chk("mid_rst_valid", outValid, 0);
    chk("mid_rst_busy", busy, 0);
    RST = 1'b0;
    for (int k = 1; k <= 4; k++) beat(pk(k, 0, 0), 1'b0);
    idle(2);
    chk("post_rst_count", got.size(), b + 1);
    expect_lane("post_rst_max", b, 0, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end
endmodule
